msi001_spi_seq: RTL and testbench

Parametrised SPI register-write sequencer for the MSi001 tuner and similar write-only SPI slaves. It shifts a table of NWORDS configuration words of WIDTH bits, one framed transaction per word. Each transaction has a programmable SCLK divider, clock polarity, bit order and inter-word gap. It runs on the PLL-derived SPI clock domain and replaces the single fixed 24-bit writer with a start/busy/done handshake.

---
 rtl/msi001_spi_seq_if.sv | 26 ++
 rtl/msi001_spi_seq.sv | 181 ++++++++++++++++++
 tb/tb_msi001_spi_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/msi001_spi_seq_if.sv
// Handshake and serial-pin bundle between a sequencer and its controller.
interface msi001_spi_seq_if #(
  parameter int WIDTH  = 24,
  parameter int NWORDS = 4
);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic                     start;
  logic [NWORDS*WIDTH-1:0]  words_in;
  logic                     busy;
  logic                     done;
  logic [IW-1:0]            word_idx;
  logic                     spi_data_out;
  logic                     spi_clk_out;
  logic                     spi_en_out;

  modport master (
    output start, words_in,
    input  busy, done, word_idx, spi_data_out, spi_clk_out, spi_en_out
  );

  modport slave (
    input  start, words_in,
    output busy, done, word_idx, spi_data_out, spi_clk_out, spi_en_out
  );
endinterface

// File: rtl/msi001_spi_seq.sv
// SPI register-write sequencer: shifts NWORDS latched words, one EN-framed
// transaction per word, with start/busy/done handshake.
//
// state   | meaning
// IDLE    | waiting for start, outputs idle
// SHIFT_A | SCLK at CPOL for CLK_DIV cycles, data settling
// SHIFT_B | SCLK at ~CPOL for CLK_DIV cycles (leading edge entered here)
// HOLD    | last bit held CLK_DIV cycles with SCLK back at CPOL
// GAP     | EN inactive GAP_CYCLES cycles between words
// DONE    | one-cycle done pulse
module msi001_spi_seq #(
  parameter int WIDTH         = 24,
  parameter int NWORDS        = 4,
  parameter int CLK_DIV       = 4,
  parameter bit CPOL          = 1'b0,
  parameter bit MSB_FIRST     = 1'b1,
  parameter int GAP_CYCLES    = 8,
  parameter bit EN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  msi001_spi_seq_if.slave bus
);

  localparam int TOT  = NWORDS * WIDTH;
  localparam int IW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BW   = $clog2(WIDTH);
  localparam int TMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]  DIV_LD   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]  GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [TOT-1:0] LSB_MASK = TOT'(1);
  localparam logic           EN_ON    = ~EN_ACTIVE_LOW;
  localparam logic           EN_OFF   = EN_ACTIVE_LOW;

  typedef enum logic [2:0] {IDLE, SHIFT_A, SHIFT_B, HOLD, GAP, DONE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TOT-1:0]  shadow_q, shadow_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sclk_q, sclk_d;
  logic            en_q, en_d;
  logic            data_q, data_d;

  logic tc, last_bit, last_word;

  assign tc        = (tmr_q == '0);
  assign last_bit  = (bit_q == BW'(WIDTH - 1));
  assign last_word = (idx_q == IW'(NWORDS - 1));

  // Serial bit b of word k, honouring the configured bit order.
  function automatic logic pick(input logic [TOT-1:0] tbl,
                                input logic [IW-1:0] k,
                                input logic [BW-1:0] b);
    int             pos;
    logic [TOT-1:0] s;
    pos = MSB_FIRST ? (WIDTH - 1 - int'(b)) : int'(b);
    s   = tbl >> (int'(k) * WIDTH + pos);
    return |(s & LSB_MASK);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= CPOL;
      en_q     <= EN_OFF;
      data_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      en_q     <= en_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tc ? tmr_q : tmr_q - TW'(1);
    bit_d   = bit_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT_A;
        tmr_d   = DIV_LD;
        bit_d   = '0;
        idx_d   = '0;
      end
      SHIFT_A: if (tc) begin
        state_d = SHIFT_B;
        tmr_d   = DIV_LD;
      end
      SHIFT_B: if (tc) begin
        tmr_d = DIV_LD;
        if (last_bit) begin
          state_d = HOLD;
        end else begin
          state_d = SHIFT_A;
          bit_d   = bit_q + BW'(1);
        end
      end
      HOLD: if (tc) begin
        if (last_word) begin
          state_d = DONE;
        end else begin
          state_d = GAP;
          tmr_d   = GAP_LD;
        end
      end
      GAP: if (tc) begin
        state_d = SHIFT_A;
        tmr_d   = DIV_LD;
        bit_d   = '0;
        idx_d   = idx_q + IW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    en_d     = en_q;
    data_d   = data_q;
    case (state_q)
      IDLE: if (bus.start) begin
        shadow_d = bus.words_in;
        busy_d   = 1'b1;
        en_d     = EN_ON;
        sclk_d   = CPOL;
        data_d   = pick(bus.words_in, '0, '0);
      end
      SHIFT_A: if (tc) sclk_d = ~CPOL;
      SHIFT_B: if (tc) begin
        sclk_d = CPOL;
        // next bit launches on the trailing edge so it is stable a full half-period
        if (!last_bit) data_d = pick(shadow_q, idx_q, bit_q + BW'(1));
      end
      HOLD: if (tc) begin
        en_d   = EN_OFF;
        data_d = 1'b0;
        if (last_word) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      GAP: if (tc) begin
        en_d   = EN_ON;
        data_d = pick(shadow_q, idx_q + IW'(1), '0);
      end
      default: ;
    endcase
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.word_idx     = idx_q;
  assign bus.spi_data_out = data_q;
  assign bus.spi_clk_out  = sclk_q;
  assign bus.spi_en_out   = en_q;

endmodule

// File: tb/tb_msi001_spi_seq.sv
// Bench for msi001_spi_seq: three parameterisations, waveform decoded frame by frame.
module tb_msi001_spi_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msi001_spi_seq_if #(.WIDTH(24), .NWORDS(4)) if0 ();
  msi001_spi_seq_if #(.WIDTH(8),  .NWORDS(1)) if1 ();
  msi001_spi_seq_if #(.WIDTH(5),  .NWORDS(3)) if2 ();

  msi001_spi_seq u0 (.clk(clk), .rst(rst), .bus(if0));
  msi001_spi_seq #(.WIDTH(8), .NWORDS(1), .CLK_DIV(1), .CPOL(1'b1), .MSB_FIRST(1'b0))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  msi001_spi_seq #(.WIDTH(5), .NWORDS(3), .CLK_DIV(2), .GAP_CYCLES(1), .EN_ACTIVE_LOW(1'b0))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct packed {
    logic en; logic sclk; logic data; logic busy; logic done; logic [3:0] idx;
  } smp_t;
  typedef struct packed {
    logic en; logic sclk; logic data; logic busy; logic done;
  } vec_t;

  smp_t        tr[$];
  int unsigned exp_w[16];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic smp_t grab(input int which);
    smp_t s;
    s = '0;
    case (which)
      0: s = {if0.spi_en_out, if0.spi_clk_out, if0.spi_data_out, if0.busy, if0.done, 4'(if0.word_idx)};
      1: s = {if1.spi_en_out, if1.spi_clk_out, if1.spi_data_out, if1.busy, if1.done, 4'(if1.word_idx)};
      default: s = {if2.spi_en_out, if2.spi_clk_out, if2.spi_data_out, if2.busy, if2.done, 4'(if2.word_idx)};
    endcase
    return s;
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0: if0.start = v;
      1: if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  task automatic rand_words(input int which);
    case (which)
      0: for (int k = 0; k < 4; k++) begin
        exp_w[k] = $urandom & 32'hFF_FFFF;
        if0.words_in[k*24 +: 24] = exp_w[k][23:0];
      end
      default: for (int k = 0; k < 3; k++) begin
        exp_w[k] = $urandom & 32'h1F;
        if2.words_in[k*5 +: 5] = exp_w[k][4:0];
      end
    endcase
  endtask

  // Start pulse on the next edge, then record ncap cycles sampled at negedge.
  task automatic go(input int which, input int ncap);
    tr.delete();
    set_start(which, 1'b1);
    for (int i = 0; i < ncap; i++) begin
      @(negedge clk);
      tr.push_back(grab(which));
      set_start(which, 1'b0);
    end
  endtask

  // Reference: decode the trace from tr[base] (first cycle after accept)
  // into frames and compare against the expected words and framing lengths.
  task automatic analyze(input string tag, input int base, input int nw, input int width,
                         input int cdiv, input bit cpol, input bit msb, input bit en_low,
                         input int gap);
    int t, f, len, edges, nb, gl, idle_bad, hs_bad, first_done;
    bit in_f, prev, a;
    longint unsigned val;
    t = nw * (2 * cdiv * width + cdiv) + (nw - 1) * gap;
    f = 0; len = 0; edges = 0; nb = 0; gl = 0; idle_bad = 0; hs_bad = 0; first_done = -1;
    in_f = 1'b0; prev = cpol; val = 0;
    if (base + t >= tr.size()) begin
      chk({tag, " window"}, tr.size(), base + t + 1);
      return;
    end
    for (int i = base; i <= base + t; i++) begin
      a = en_low ? ~tr[i].en : tr[i].en;
      if (tr[i].done && first_done < 0) first_done = i - base;
      if ((i < base + t) != tr[i].busy || (i == base + t) != tr[i].done) hs_bad++;
      if (a) begin
        if (!in_f) begin
          f++; len = 0; edges = 0; nb = 0; val = 0; in_f = 1'b1;
          if (f > 1) chk({tag, " gap length"}, gl, gap);
          chk({tag, " word_idx"}, tr[i].idx, f - 1);
        end
        len++;
        if (tr[i].sclk != cpol && prev == cpol) begin
          edges++;
          if (msb) val = (val << 1) | longint'(tr[i].data);
          else     val = val | (longint'(tr[i].data) << nb);
          nb++;
        end
      end else begin
        if (in_f) begin
          in_f = 1'b0;
          chk({tag, " en length"}, len, 2 * cdiv * width + cdiv);
          chk({tag, " leading edges"}, edges, width);
          chk({tag, " word data"}, val, exp_w[(f - 1) % 16]);
          gl = 0;
        end
        gl++;
        if (tr[i].sclk != cpol || tr[i].data) idle_bad++;
      end
      prev = tr[i].sclk;
    end
    chk({tag, " frame count"}, f, nw);
    chk({tag, " done latency"}, first_done, t);
    chk({tag, " busy/done shape"}, hs_bad, 0);
    chk({tag, " idle pins"}, idle_bad, 0);
  endtask

  initial begin
    vec_t            tbl[19];
    smp_t            s;
    int unsigned     b_w[4];
    logic [95:0]     bv;
    int              cnt;

    tbl = '{5'b01110, 5'b00110, 5'b01010, 5'b00010, 5'b01110, 5'b00110, 5'b01010,
            5'b00010, 5'b01010, 5'b00010, 5'b01110, 5'b00110, 5'b01010, 5'b00010,
            5'b01110, 5'b00110, 5'b01110, 5'b11001, 5'b11000};

    rst = 1'b1;
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
    if0.words_in = '0; if1.words_in = '0; if2.words_in = '0;

    // reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset u0", grab(0), 9'h100);
    chk("reset u1 sclk/en", {if1.spi_clk_out, if1.spi_en_out}, 2'b11);
    chk("reset u2 sclk/en", {if2.spi_clk_out, if2.spi_en_out}, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle u0", grab(0), 9'h100);
    end

    // fixed words, default parameters
    if0.words_in = {24'hFFFFFF, 24'h000000, 24'h123456, 24'hEBAEAB};
    exp_w[0] = 32'hEBAEAB; exp_w[1] = 32'h123456; exp_w[2] = 32'h0; exp_w[3] = 32'hFFFFFF;
    go(0, 812);
    analyze("fixed", 0, 4, 24, 4, 1'b0, 1'b1, 1'b1, 8);

    // CPOL=1, LSB first, single 8-bit word: cycle-exact table
    if1.words_in = 8'hA5;
    exp_w[0] = 32'hA5;
    go(1, 20);
    for (int k = 0; k < 19; k++)
      chk($sformatf("cpol1 cycle %0d", k),
          {tr[k].en, tr[k].sclk, tr[k].data, tr[k].busy, tr[k].done}, tbl[k]);
    analyze("cpol1", 0, 1, 8, 1, 1'b1, 1'b0, 1'b1, 8);

    // random words, default parameters
    for (int r = 0; r < 3; r++) begin
      rand_words(0);
      go(0, 812);
      analyze("rand u0", 0, 4, 24, 4, 1'b0, 1'b1, 1'b1, 8);
    end

    // start held high, words changed mid-sequence, back-to-back restart
    rand_words(0);
    for (int k = 0; k < 4; k++) begin
      b_w[k] = ~exp_w[k] & 32'hFF_FFFF;
      bv[k*24 +: 24] = b_w[k][23:0];
    end
    tr.delete();
    if0.start = 1'b1;
    for (int i = 0; i < 1625; i++) begin
      @(negedge clk);
      tr.push_back(grab(0));
      if (i == 100)  if0.words_in = bv;
      if (i == 1000) if0.start = 1'b0;
    end
    analyze("held seq1", 0, 4, 24, 4, 1'b0, 1'b1, 1'b1, 8);
    chk("held idle after done", {tr[809].en, tr[809].busy, tr[809].done}, 3'b100);
    for (int k = 0; k < 4; k++) exp_w[k] = b_w[k];
    analyze("held seq2", 810, 4, 24, 4, 1'b0, 1'b1, 1'b1, 8);
    chk("held no third", {tr[1620].en, tr[1620].busy}, 2'b10);

    // reset in word 2, bit 10
    rand_words(0);
    go(0, 490);
    chk("abort word_idx", tr[489].idx, 2);
    chk("abort en active", tr[489].en, 0);
    rst = 1'b1;
    @(negedge clk);
    s = grab(0);
    chk("abort outputs", s, 9'h100);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      s = grab(0);
      if (s.done || !s.en || s.busy) cnt++;
    end
    chk("abort quiet", cnt, 0);
    rand_words(0);
    go(0, 812);
    analyze("after abort", 0, 4, 24, 4, 1'b0, 1'b1, 1'b1, 8);

    // active-high EN, one-cycle gap
    for (int r = 0; r < 5; r++) begin
      rand_words(2);
      go(2, 72);
      analyze("en high", 0, 3, 5, 2, 1'b0, 1'b1, 1'b0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
